// File: rtl/bus_select_encoder.sv
// Source-side bus select encoder: fixed-priority arbitration of one-hot drive
// requests into a registered 5-bit mux select, with sticky error flags and a fault counter.
module bus_select_encoder #(
    parameter int                 NUM_SRC    = 32,
    parameter logic [NUM_SRC-1:0] VALID_MASK = 32'h06FF_FFFF,
    parameter logic [4:0]         IDLE_SEL   = 5'd0,
    parameter int                 CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] drive_req,
    input  logic               err_clear,
    output logic [4:0]         select,
    output logic               select_valid,
    output logic [NUM_SRC-1:0] grant,
    output logic               collision_err,
    output logic               illegal_err,
    output logic [CNT_W-1:0]   fault_count
);

    logic [NUM_SRC-1:0] legal_s;
    logic [NUM_SRC-1:0] illegal_s;
    logic [4:0]         win_idx_s;
    logic               any_legal_s;
    logic               coll_now_s;
    logic               ill_now_s;
    logic               fault_now_s;

    logic [4:0]         select_q,    select_d;
    logic               valid_q,     valid_d;
    logic [NUM_SRC-1:0] grant_q,     grant_d;
    logic               coll_q,      coll_d;
    logic               ill_q,       ill_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    // Request classification and lowest-index priority encode.
    always_comb begin
        legal_s     = drive_req & VALID_MASK;
        illegal_s   = drive_req & ~VALID_MASK;
        any_legal_s = (legal_s != {NUM_SRC{1'b0}});
        // Clearing the lowest set bit leaves something only if two or more were set.
        coll_now_s  = ((legal_s & (legal_s - {{(NUM_SRC-1){1'b0}}, 1'b1})) != {NUM_SRC{1'b0}});
        ill_now_s   = (illegal_s != {NUM_SRC{1'b0}});
        fault_now_s = coll_now_s | ill_now_s;
        win_idx_s   = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (legal_s[i]) begin
                win_idx_s = 5'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Next-state for select/grant and the error bookkeeping.
    always_comb begin
        select_d = select_q;
        valid_d  = 1'b0;
        grant_d  = {NUM_SRC{1'b0}};
        if (any_legal_s) begin
            select_d = win_idx_s;
            valid_d  = 1'b1;
            grant_d  = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            select_d = select_q;
        end

        if (err_clear) begin
            coll_d = coll_now_s;
            ill_d  = ill_now_s;
            cnt_d  = fault_now_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else begin
            coll_d = coll_q | coll_now_s;
            ill_d  = ill_q | ill_now_s;
            if (fault_now_s && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Single register stage; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            select_q <= IDLE_SEL;
            valid_q  <= 1'b0;
            grant_q  <= {NUM_SRC{1'b0}};
            coll_q   <= 1'b0;
            ill_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            select_q <= select_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            coll_q   <= coll_d;
            ill_q    <= ill_d;
            cnt_q    <= cnt_d;
        end
    end

    assign select        = select_q;
    assign select_valid  = valid_q;
    assign grant         = grant_q;
    assign collision_err = coll_q;
    assign illegal_err   = ill_q;
    assign fault_count   = cnt_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Self-checking bench for bus_select_encoder: directed plan steps plus random
// traffic, all compared against a behavioural reference model.
module tb_bus_select_encoder;

    localparam logic [31:0] MASK = 32'h06FF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] drive_req;
    logic        err_clear;
    logic [4:0]  select;
    logic        select_valid;
    logic [31:0] grant;
    logic        collision_err;
    logic        illegal_err;
    logic [7:0]  fault_count;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_sel;
    bit          m_valid;
    logic [31:0] m_grant;
    bit          m_coll;
    bit          m_ill;
    int          m_cnt;

    bus_select_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .drive_req    (drive_req),
        .err_clear    (err_clear),
        .select       (select),
        .select_valid (select_valid),
        .grant        (grant),
        .collision_err(collision_err),
        .illegal_err  (illegal_err),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model the edge: lowest legal index wins, popcount decides collisions.
    task automatic model_edge(input logic [31:0] req, input bit clr, input bit rst);
        logic [31:0] legal;
        bit          coll_now, ill_now;
        legal    = req & MASK;
        coll_now = ($countones(legal) >= 2);
        ill_now  = ((req & ~MASK) != 32'd0);
        if (rst) begin
            m_sel = 0; m_valid = 0; m_grant = 32'd0; m_coll = 0; m_ill = 0; m_cnt = 0;
        end else begin
            m_valid = 0;
            m_grant = 32'd0;
            for (int k = 0; k < 32; k++) begin
                if (legal[k] && !m_valid) begin
                    m_sel   = k;
                    m_valid = 1;
                    m_grant = 32'd1 << k;
                end
            end
            if (clr) begin
                m_coll = coll_now;
                m_ill  = ill_now;
                m_cnt  = (coll_now || ill_now) ? 1 : 0;
            end else begin
                m_coll = m_coll | coll_now;
                m_ill  = m_ill | ill_now;
                if ((coll_now || ill_now) && m_cnt < 255) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic step(input logic [31:0] req, input bit clr, input bit rst, input string tag);
        reset     = rst;
        drive_req = req;
        err_clear = clr;
        @(posedge clk);
        model_edge(req, clr, rst);
        #1;
        check({tag, ".select"},   {27'd0, select},        32'(m_sel));
        check({tag, ".valid"},    {31'd0, select_valid},  {31'd0, m_valid});
        check({tag, ".grant"},    grant,                  m_grant);
        check({tag, ".coll"},     {31'd0, collision_err}, {31'd0, m_coll});
        check({tag, ".ill"},      {31'd0, illegal_err},   {31'd0, m_ill});
        check({tag, ".count"},    {24'd0, fault_count},   32'(m_cnt));
        if (select_valid) check({tag, ".inv_onehot"}, grant, 32'd1 << select);
        else              check({tag, ".inv_zero"},   grant, 32'd0);
    endtask

    initial begin
        int slots[$];
        reset = 1'b1; drive_req = 32'd0; err_clear = 1'b0;
        step(32'd0, 0, 1, "init_rst");
        step(32'd0, 0, 1, "init_rst2");

        // Reset mid-stream.
        step(32'h0000_0010, 0, 0, "mid_a");
        step(32'h0000_0010, 0, 1, "mid_rst");
        check("mid_rst.sel0", {27'd0, select}, 32'd0);
        step(32'h0000_0010, 0, 0, "mid_c");
        check("mid_c.grant10", grant, 32'h10);

        // Single legal sweep.
        for (int i = 0; i < 27; i++) begin
            if (i != 24) step(32'd1 << i, 0, 0, $sformatf("sweep%0d", i));
        end

        // Collision then idle.
        step(32'h0200_0108, 0, 0, "coll");
        check("coll.sel3", {27'd0, select}, 32'd3);
        step(32'd0, 0, 0, "coll_idle");

        // Illegal only, then mixed.
        step(32'h0100_0000, 0, 0, "ill_only");
        step(32'h8100_0002, 0, 0, "ill_mix");
        check("ill_mix.sel1", {27'd0, select}, 32'd1);

        // Saturation and clear.
        for (int i = 0; i < 300; i++) step(32'h0000_0003, 0, 0, "sat");
        check("sat.255", {24'd0, fault_count}, 32'd255);
        step(32'h0000_0006, 1, 0, "clr_fault");
        check("clr_fault.cnt1", {24'd0, fault_count}, 32'd1);
        step(32'd0, 1, 0, "clr_idle");
        check("clr_idle.cnt0", {24'd0, fault_count}, 32'd0);

        // Back-to-back grants.
        step(32'h0000_0001, 0, 0, "b2b_0");
        step(32'h4000_0000, 0, 0, "b2b_ill");
        step(32'h0400_0000, 0, 0, "b2b_26");
        check("b2b_26.sel", {27'd0, select}, 32'd26);

        // Random traffic.
        for (int i = 0; i < 27; i++) if (i != 24) slots.push_back(i);
        for (int n = 0; n < 600; n++) begin
            int          mode;
            logic [31:0] req;
            mode = $urandom_range(0, 9);
            case (mode)
                0, 1, 2, 3: req = 32'd1 << slots[$urandom_range(0, slots.size() - 1)];
                4:          req = 32'd0;
                5:          req = 32'd1 << $urandom_range(0, 31);
                default:    req = $urandom & $urandom;
            endcase
            step(req, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
